// File: rtl/inst_mem_loader_if.sv
// rtl/inst_mem_loader_if.sv - byte stream in and instruction-memory write port of the program loader
interface inst_mem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - framed byte-stream loader packing little-endian words into instruction memory
module inst_mem_loader #(
   parameter int         ADDR_W = 8,
   parameter logic [7:0] SYNC   = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   inst_mem_loader_if.slave  bus,
   output logic              core_rst,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'(2**ADDR_W);

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [7:0]  chk;
   logic [15:0] len;
   logic [23:0] word_buf;
   logic        accept;
   logic [15:0] len_full;
   logic [16:0] next_count;

   assign accept     = bus.rx_valid && bus.rx_ready;
   assign len_full   = {bus.rx_data, len[7:0]};
   assign next_count = 17'(words_loaded) + 17'd1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         bus.rx_ready  <= 1'b1;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         core_rst      <= 1'b1;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
         words_loaded  <= '0;
         byte_cnt      <= '0;
         chk           <= '0;
         len           <= '0;
         word_buf      <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         if (accept) begin
            case (state)
               S_IDLE: begin
                  if (bus.rx_data == SYNC) begin
                     state        <= S_LEN_LO;
                     chk          <= '0;
                     byte_cnt     <= '0;
                     words_loaded <= '0;
                  end
               end
               S_LEN_LO: begin
                  len[7:0] <= bus.rx_data;
                  chk      <= bus.rx_data;
                  state    <= S_LEN_HI;
               end
               S_LEN_HI: begin
                  len[15:8] <= bus.rx_data;
                  chk       <= chk ^ bus.rx_data;
                  // Oversized images are rejected before any word reaches memory.
                  if (17'(len_full) > MAX_WORDS) begin
                     state        <= S_ERR;
                     bus.rx_ready <= 1'b0;
                     load_err     <= 1'b1;
                  end else if (len_full == 16'd0) begin
                     state <= S_CHK;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  chk      <= chk ^ bus.rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     bus.mem_we    <= 1'b1;
                     bus.mem_wdata <= {bus.rx_data, word_buf};
                     bus.mem_addr  <= words_loaded[ADDR_W-1:0];
                     words_loaded  <= words_loaded + 1'b1;
                     if (next_count == 17'(len))
                        state <= S_CHK;
                  end else begin
                     word_buf[8*byte_cnt +: 8] <= bus.rx_data;
                  end
               end
               S_CHK: begin
                  bus.rx_ready <= 1'b0;
                  if (bus.rx_data == chk) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                     core_rst  <= 1'b0;
                  end else begin
                     state    <= S_ERR;
                     load_err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - scoreboard bench for the program loader
module tb_inst_mem_loader;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       core_rst;
   logic       load_done;
   logic       load_err;
   logic [8:0] words_loaded;

   always #5 clk = ~clk;

   inst_mem_loader_if #(.ADDR_W(8)) bus ();

   inst_mem_loader #(.ADDR_W(8), .SYNC(8'hA5)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .core_rst     (core_rst),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_chk  = 0;
   int  n_fail = 0;
   logic prev_we = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse is matched against the next expected word.
   always @(negedge clk) begin
      wr_t e;
      if (load_done || load_err)
         check("flags_exclusive", 64'(load_done & load_err), 64'd0);
      if (bus.mem_we) begin
         check("we_single_pulse", 64'(prev_we), 64'd0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_we: got addr %0h data %0h expected no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("we_addr", 64'(bus.mem_addr), 64'(e.addr));
            check("we_data", 64'(bus.mem_wdata), 64'(e.data));
            check("we_count", 64'(words_loaded), 64'(e.addr) + 64'd1);
         end
      end
      prev_we = bus.mem_we;
   end

   task automatic send(input logic [7:0] b, input int gap);
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         bus.rx_valid = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk);
   endtask

   task automatic pick_gap(input int gmax, output int g);
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
   endtask

   // Sends a complete frame; the checksum is corrupted when bad_chk is set.
   task automatic frame(input logic [15:0] n, input logic [31:0] words[$],
                        input bit bad_chk, input int gmax);
      logic [7:0] c;
      logic [7:0] b;
      wr_t        w;
      int         g;
      c = n[7:0] ^ n[15:8];
      send(8'hA5, 0);
      send(n[7:0], 0);
      send(n[15:8], 0);
      for (int i = 0; i < words.size(); i++) begin
         for (int k = 0; k < 4; k++) begin
            b = words[i][8*k +: 8];
            c = c ^ b;
            if (k == 3) begin
               w.addr = 8'(i);
               w.data = words[i];
               exp_q.push_back(w);
            end
            pick_gap(gmax, g);
            send(b, g);
         end
      end
      send(bad_chk ? (c ^ 8'h5A) : c, 0);
   endtask

   task automatic release_bus();
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b0;
      bus.rx_valid = 1'b0;
      @(negedge clk);
      check("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check("rst_core_rst", 64'(core_rst), 64'd1);
      check("rst_load_done", 64'(load_done), 64'd0);
      check("rst_load_err", 64'(load_err), 64'd0);
      check("rst_words", 64'(words_loaded), 64'd0);
      rst = 1'b1;
   endtask

   task automatic expect_status(input string tag, input bit done, input bit err, input int nw);
      check({tag, "_done"}, 64'(load_done), 64'(done));
      check({tag, "_err"}, 64'(load_err), 64'(err));
      check({tag, "_core_rst"}, 64'(core_rst), 64'(!done));
      check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
      check({tag, "_words"}, 64'(words_loaded), 64'(nw));
      check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   logic [31:0] prog[$];
   logic [31:0] none[$];
   logic [31:0] three[$];
   logic [31:0] full[$];

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      prog  = '{32'h00100513, 32'h00000093};
      three = '{32'h11223344, 32'hCAFEBABE, 32'h0000FF00};
      for (int i = 0; i < 256; i++)
         full.push_back((32'(i) * 32'h01010101) ^ 32'hDEAD0000);

      do_reset();
      frame(16'd2, prog, 1'b0, 0);
      release_bus();
      expect_status("good", 1'b1, 1'b0, 2);
      send(8'hA5, 0);
      release_bus();
      repeat (3) @(negedge clk);
      expect_status("after_done", 1'b1, 1'b0, 2);

      do_reset();
      frame(16'd2, prog, 1'b1, 0);
      release_bus();
      expect_status("bad_chk", 1'b0, 1'b1, 2);

      do_reset();
      send(8'h00, 0);
      send(8'hFF, 0);
      send(8'h5A, 0);
      frame(16'd0, none, 1'b0, 0);
      release_bus();
      expect_status("empty", 1'b1, 1'b0, 0);

      do_reset();
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h01, 0);
      release_bus();
      expect_status("too_long", 1'b0, 1'b1, 0);

      do_reset();
      frame(16'd3, three, 1'b0, 3);
      release_bus();
      expect_status("gaps", 1'b1, 1'b0, 3);

      do_reset();
      frame(16'd256, full, 1'b0, 0);
      release_bus();
      expect_status("max_len", 1'b1, 1'b0, 256);

      do_reset();
      begin
         wr_t w;
         send(8'hA5, 0);
         send(8'h02, 0);
         send(8'h00, 0);
         for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
               w.addr = 8'h00;
               w.data = prog[0];
               exp_q.push_back(w);
            end
            send(prog[0][8*k +: 8], 0);
         end
         send(prog[1][7:0], 0);
         send(prog[1][15:8], 0);
      end
      do_reset();
      frame(16'd2, prog, 1'b0, 1);
      release_bus();
      expect_status("after_abort", 1'b1, 1'b0, 2);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
